// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider configuration path.
// Also imported by the divider testbench.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    LOAD    = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam int unsigned MIN_RATIO = 2;

  // Ratios 0 and 1 cannot be produced by the divider.
  function automatic logic ratio_valid(input logic [31:0] ratio);
    return ratio >= MIN_RATIO;
  endfunction

endpackage

// File: rtl/clk_div_settle_cnt.sv
// Loadable down-counter that times the quiesce window before a ratio change.
// Reloaded on every entry to QUIESCE, so it never needs to wrap.
module clk_div_settle_cnt #(
  parameter int SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Sequences ratio changes into the integer divider: disable, wait, move ratio,
// re-enable. The divider never sees an illegal ratio or a change while enabled.
module clk_div_cfg_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W         = 8,
  parameter int SETTLE_CYC    = 4,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic             I_ref_clk,
  input  logic             I_rst_n,
  input  logic             I_enable,
  input  logic             I_req_valid,
  input  logic [DIV_W-1:0] I_req_ratio,
  output logic             o_req_ready,
  input  logic             I_err_clr,
  output logic [DIV_W-1:0] o_div_ratio,
  output logic             o_clk_en,
  output logic             o_busy,
  output logic             o_err
);

  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("clk_div_cfg_ctrl: SETTLE_CYC must be >= 1");
  end
  if (DEFAULT_RATIO < int'(MIN_RATIO)) begin : g_bad_default
    $error("clk_div_cfg_ctrl: DEFAULT_RATIO must be >= 2");
  end

  state_t           state, next_state;
  logic [DIV_W-1:0] shadow;
  logic             accept, req_ok, reject, cnt_zero, cnt_load;
  logic             clk_en_d, busy_d, ready_d;

  assign accept   = I_req_valid && o_req_ready;
  assign req_ok   = ratio_valid(32'(I_req_ratio));
  assign reject   = accept && !req_ok;
  assign cnt_load = accept && req_ok && (state == RUN);

  clk_div_settle_cnt #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle_cnt (
    .clk   (I_ref_clk),
    .rst_n (I_rst_n),
    .load  (cnt_load),
    .dec   (state == QUIESCE),
    .zero  (cnt_zero)
  );

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= IDLE;
      o_clk_en    <= 1'b0;
      o_busy      <= 1'b0;
      o_req_ready <= 1'b0;
    end else begin
      state       <= next_state;
      o_clk_en    <= clk_en_d;
      o_busy      <= busy_d;
      o_req_ready <= ready_d;
    end
  end

  // A rejected request holds the current state, even if I_enable has moved.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_ok) next_state = LOAD;
        end else if (I_enable) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (req_ok) next_state = QUIESCE;
        end else if (!I_enable) begin
          next_state = IDLE;
        end
      end
      QUIESCE: if (cnt_zero) next_state = LOAD;
      LOAD:    next_state = I_enable ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    clk_en_d = (next_state == RUN);
    busy_d   = (next_state == QUIESCE) || (next_state == LOAD);
    ready_d  = (next_state == IDLE) || (next_state == RUN);
  end

  // From IDLE the divider is already disabled, so the ratio can move at once.
  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      o_div_ratio <= DIV_W'(DEFAULT_RATIO);
      shadow      <= DIV_W'(DEFAULT_RATIO);
    end else begin
      if (accept && req_ok) shadow <= I_req_ratio;
      if ((state == IDLE) && accept && req_ok) begin
        o_div_ratio <= I_req_ratio;
      end else if ((state == QUIESCE) && cnt_zero) begin
        o_div_ratio <= shadow;
      end
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      o_err <= 1'b0;
    end else if (reject) begin
      o_err <= 1'b1;
    end else if (I_err_clr) begin
      o_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl with hand-computed expectations
// (DIV_W=8, SETTLE_CYC=4, DEFAULT_RATIO=2).
module tb_clk_div_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       req_valid;
  logic [7:0] req_ratio;
  logic       req_ready;
  logic       err_clr;
  logic [7:0] div_ratio;
  logic       clk_en;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;

  clk_div_cfg_ctrl #(
    .DIV_W         (8),
    .SETTLE_CYC    (4),
    .DEFAULT_RATIO (2)
  ) dut (
    .I_ref_clk   (clk),
    .I_rst_n     (rst_n),
    .I_enable    (enable),
    .I_req_valid (req_valid),
    .I_req_ratio (req_ratio),
    .o_req_ready (req_ready),
    .I_err_clr   (err_clr),
    .o_div_ratio (div_ratio),
    .o_clk_en    (clk_en),
    .o_busy      (busy),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; req_valid = 1'b0; req_ratio = 8'd0; err_clr = 1'b0;
    repeat (3) tick();
    checks++; if (div_ratio !== 8'd2) begin errors++; $display("[TB] FAIL rst_ratio: got %0d expected 2", div_ratio); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_clk_en: got %b expected 0", clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b expected 0", err); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 0", req_ready); end
    rst_n = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready_after: got %b expected 1", req_ready); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_clk_en: got %b expected 0", clk_en); end
  endtask

  task automatic test_start();
    enable = 1'b1;
    tick();
    checks++; if (clk_en !== 1'b1) begin errors++; $display("[TB] FAIL start_clk_en: got %b expected 1", clk_en); end
    checks++; if (div_ratio !== 8'd2) begin errors++; $display("[TB] FAIL start_ratio: got %0d expected 2", div_ratio); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL start_err: got %b expected 0", err); end
  endtask

  task automatic test_change_from_run();
    int low_cnt;
    logic [7:0] exp_ratio;
    low_cnt = 0;
    req_valid = 1'b1; req_ratio = 8'd4;
    tick();
    req_valid = 1'b0; req_ratio = 8'd0;
    if (clk_en === 1'b0) low_cnt++;
    checks++; if (div_ratio !== 8'd2) begin errors++; $display("[TB] FAIL run_chg_k_ratio: got %0d expected 2", div_ratio); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL run_chg_k_busy: got %b expected 1", busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL run_chg_k_ready: got %b expected 0", req_ready); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (clk_en === 1'b0) low_cnt++;
      exp_ratio = (i == 4) ? 8'd4 : 8'd2;
      checks++; if (div_ratio !== exp_ratio) begin errors++; $display("[TB] FAIL run_chg_ratio_k%0d: got %0d expected %0d", i, div_ratio, exp_ratio); end
      checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL run_chg_clk_en_k%0d: got %b expected 0", i, clk_en); end
    end
    tick();
    checks++; if (clk_en !== 1'b1) begin errors++; $display("[TB] FAIL run_chg_k5_clk_en: got %b expected 1", clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL run_chg_k5_busy: got %b expected 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL run_chg_k5_ready: got %b expected 1", req_ready); end
    checks++; if (low_cnt != 5) begin errors++; $display("[TB] FAIL run_chg_low_cycles: got %0d expected 5", low_cnt); end
  endtask

  task automatic test_reject();
    req_valid = 1'b1; req_ratio = 8'd0;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL rej0_err: got %b expected 1", err); end
    checks++; if (div_ratio !== 8'd4) begin errors++; $display("[TB] FAIL rej0_ratio: got %0d expected 4", div_ratio); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("[TB] FAIL rej0_clk_en: got %b expected 1", clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rej0_busy: got %b expected 0", busy); end
    req_ratio = 8'd1;
    tick();
    req_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL rej1_err: got %b expected 1", err); end
    checks++; if (div_ratio !== 8'd4) begin errors++; $display("[TB] FAIL rej1_ratio: got %0d expected 4", div_ratio); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rej1_ready: got %b expected 1", req_ready); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clr: got %b expected 0", err); end
    req_valid = 1'b1; req_ratio = 8'd1; err_clr = 1'b1;
    tick();
    req_valid = 1'b0; err_clr = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_set_wins: got %b expected 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clr2: got %b expected 0", err); end
  endtask

  task automatic test_change_from_idle();
    enable = 1'b0;
    tick();
    checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_stop_clk_en: got %b expected 0", clk_en); end
    req_valid = 1'b1; req_ratio = 8'd3;
    tick();
    req_valid = 1'b0; req_ratio = 8'd0;
    checks++; if (div_ratio !== 8'd3) begin errors++; $display("[TB] FAIL idle_chg_ratio: got %0d expected 3", div_ratio); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL idle_chg_busy: got %b expected 1", busy); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_chg_clk_en: got %b expected 0", clk_en); end
    enable = 1'b1;
    tick();
    checks++; if (clk_en !== 1'b1) begin errors++; $display("[TB] FAIL idle_load_exit_clk_en: got %b expected 1", clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_load_exit_busy: got %b expected 0", busy); end
    checks++; if (div_ratio !== 8'd3) begin errors++; $display("[TB] FAIL idle_load_exit_ratio: got %0d expected 3", div_ratio); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_ratio = 8'd8; enable = 1'b0;
    tick();
    req_valid = 1'b0; req_ratio = 8'd0;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_k_clk_en: got %b expected 0", clk_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_k_busy: got %b expected 1", busy); end
    enable = 1'b1;
    repeat (2) tick();
    enable = 1'b0;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_toggle_clk_en: got %b expected 0", clk_en); end
    checks++; if (div_ratio !== 8'd3) begin errors++; $display("[TB] FAIL b2b_mid_ratio: got %0d expected 3", div_ratio); end
    repeat (2) tick();
    checks++; if (div_ratio !== 8'd8) begin errors++; $display("[TB] FAIL b2b_ratio: got %0d expected 8", div_ratio); end
    tick();
    checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_final_clk_en: got %b expected 0", clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_final_busy: got %b expected 0", busy); end
    tick();
    checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_clk_en: got %b expected 0", clk_en); end
  endtask

  task automatic test_reset_mid_quiesce();
    enable = 1'b1;
    tick();
    req_valid = 1'b1; req_ratio = 8'd5;
    tick();
    req_valid = 1'b0; req_ratio = 8'd0; enable = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_clk_en: got %b expected 0", clk_en); end
    checks++; if (div_ratio !== 8'd2) begin errors++; $display("[TB] FAIL midrst_ratio: got %0d expected 2", div_ratio); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 0", req_ready); end
    #2;
    rst_n = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready_after: got %b expected 1", req_ready); end
    checks++; if (div_ratio !== 8'd2) begin errors++; $display("[TB] FAIL midrst_ratio_after: got %0d expected 2", div_ratio); end
    repeat (5) tick();
    checks++; if (div_ratio !== 8'd2) begin errors++; $display("[TB] FAIL midrst_no_resume: got %0d expected 2", div_ratio); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_change_from_run();
    test_reject();
    test_change_from_idle();
    test_back_to_back();
    test_reset_mid_quiesce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
